// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: widths, reset default and entry type shared by the fetch
// unit, its instruction queue and its bus interface.
package fetch_unit_pkg;

    localparam int PC_W       = 64;
    localparam int INSN_W     = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = '0;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // Instructions are word aligned; low address bits are forced to zero.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(INSN_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: every non-clock/reset signal of the fetch unit.
//   imem_req_*   : request channel to instruction memory (valid/ready)
//   imem_resp_*  : in-order response channel from instruction memory
//   redirect_*   : PC redirect from execute
//   fetch_*      : instruction stream to decode (valid/retry)
// master = the fetch unit, slave = its environment (memory, execute, decode).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INSN_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [INSN_W-1:0] fetch_insn;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_insn_valid;
    logic              fetch_retry;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output fetch_insn, fetch_pc, fetch_insn_valid,
        input  fetch_retry
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  fetch_insn, fetch_pc, fetch_insn_valid,
        output fetch_retry
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of {insn, pc} entries.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : empties the FIFO (wins over push/pop)
//   push/push_data : enqueue; accepted at full only together with a pop
//   pop            : dequeue the head (ignored when empty)
//   head           : current head entry (don't-care when empty)
//   count/full/empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push at full is legal then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_unit_if.master (imem request/response, redirect,
//                decode handshake)
// Issues sequential word-aligned PCs while in-flight plus buffered
// instructions stay below QDEPTH, buffers in-order responses, and hands
// them to decode. A redirect restarts both PC streams and marks every
// still-outstanding response as stale.
// QDEPTH must be a power of two, at least 2.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int               CNT_W   = $clog2(QDEPTH + 1);
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(QDEPTH);
    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(INSN_BYTES);

    logic [PC_W-1:0]  req_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [PC_W-1:0]  redirect_tgt;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   credits_used;
    logic             q_full;
    logic             q_empty;
    logic             q_pop;
    logic             req_fire;
    logic             resp_keep;
    fetch_entry_t     q_head;
    fetch_entry_t     q_in;

    assign redirect_tgt = pc_align(bus.redirect_pc);

    // Credits cover both outstanding requests (stale ones included) and
    // buffered instructions, so the queue can never overflow.
    assign credits_used = {1'b0, inflight} + {1'b0, q_count};

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (credits_used < CREDITS);
    assign bus.imem_req_addr  = req_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A response arriving with a redirect is already stale.
    assign resp_keep = bus.imem_resp_valid && (discard == '0) && !bus.redirect_valid;
    assign q_in      = {bus.imem_resp_data, resp_pc};

    assign bus.fetch_insn_valid = !reset && !q_empty && !bus.redirect_valid;
    assign bus.fetch_insn       = (reset || q_empty) ? '0 : q_head.insn;
    assign bus.fetch_pc         = (reset || q_empty) ? '0 : q_head.pc;
    assign q_pop                = bus.fetch_insn_valid && !bus.fetch_retry;

    fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (resp_keep),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc   <= pc_align(RESET_PC);
            resp_pc  <= pc_align(RESET_PC);
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
            if (bus.redirect_valid) begin
                req_pc  <= redirect_tgt;
                resp_pc <= redirect_tgt;
                // Everything still outstanding after this cycle's response
                // (already-stale or not) belongs to the old path.
                discard <= inflight - CNT_W'(bus.imem_resp_valid);
            end else begin
                if (req_fire) req_pc <= req_pc + PC_STEP;
                if (bus.imem_resp_valid) begin
                    if (discard != '0) discard <= discard - CNT_W'(1);
                    else               resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    // The credit limit makes an enqueue into a full queue impossible.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(resp_keep && q_full && !q_pop));
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          QDEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if fif ();

    fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int epoch = 0;
    int buffered = 0;      // instructions the reference says sit in the queue
    int ready_pct, resp_pct, retry_pct, lat_max, rnd;
    bit mem_hold;
    bit prev_rst = 1'b1;
    logic [63:0] exp_req_pc = RST_PC;
    mreq_t pending[$];     // memory: accepted requests awaiting a response
    exp_t  sb[$];          // scoreboard: instructions decode must see, in order
    exp_t  mon_e;

    // Memory contents: a distinct, address-dependent word per PC.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model update, evaluated mid-cycle with inputs and outputs
    // stable, describing what the coming clock edge does.
    task automatic bookkeep();
        bit    exp_rv;
        bit    exp_fv;
        mreq_t r;
        exp_rv = !reset && !fif.redirect_valid && (pending.size() + buffered < QDEPTH);
        exp_fv = !reset && !fif.redirect_valid && (buffered > 0);
        chk("imem_req_valid", 64'(fif.imem_req_valid), 64'(exp_rv));
        chk("fetch_insn_valid", 64'(fif.fetch_insn_valid), 64'(exp_fv));
        if (prev_rst && !reset) begin
            chk("reset_fetch_insn", 64'(fif.fetch_insn), 64'h0);
            chk("reset_fetch_pc", fif.fetch_pc, 64'h0);
        end
        prev_rst = reset;
        if (reset) begin
            pending.delete();
            sb.delete();
            buffered   = 0;
            epoch++;
            exp_req_pc = RST_PC;
            return;
        end
        if (fif.imem_resp_valid) begin
            r = pending.pop_front();
            if (r.epoch == epoch && !fif.redirect_valid) buffered++;
        end
        if (exp_fv && !fif.fetch_retry) buffered--;
        if (fif.redirect_valid) begin
            sb.delete();
            buffered   = 0;
            epoch++;
            exp_req_pc = {fif.redirect_pc[63:2], 2'b00};
        end else if (fif.imem_req_valid && fif.imem_req_ready) begin
            chk("imem_req_addr", fif.imem_req_addr, exp_req_pc);
            sb.push_back('{insn: mem_word(exp_req_pc), pc: exp_req_pc});
            pending.push_back('{addr: fif.imem_req_addr,
                                due: cyc + 1 + int'($urandom_range(0, lat_max)),
                                epoch: epoch});
            exp_req_pc += 64'd4;
        end
    endtask

    task automatic tick(input bit rst, input bit redir, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        cyc++;
        reset              = rst;
        fif.redirect_valid = redir;
        fif.redirect_pc    = rpc;
        fif.fetch_retry    = (int'($urandom_range(0, 99)) < retry_pct);
        fif.imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
        fif.imem_resp_valid = 1'b0;
        fif.imem_resp_data  = $urandom;
        if (!rst && !mem_hold && pending.size() > 0 && pending[0].due <= cyc
            && int'($urandom_range(0, 99)) < resp_pct) begin
            fif.imem_resp_valid = 1'b1;
            fif.imem_resp_data  = mem_word(pending[0].addr);
        end
        @(negedge clk);
        bookkeep();
    endtask

    // Monitor: every instruction decode accepts is compared with the scoreboard.
    always @(negedge clk) begin
        if (fif.fetch_insn_valid === 1'b1 && fif.fetch_retry === 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_insn: got pc 0x%0h, required no instruction (cycle %0d)",
                         fif.fetch_pc, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("fetch_pc", fif.fetch_pc, mon_e.pc);
                chk("fetch_insn", 64'(fif.fetch_insn), 64'(mon_e.insn));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fif.imem_req_ready  = 1'b0;
        fif.imem_resp_valid = 1'b0;
        fif.imem_resp_data  = '0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_pc     = '0;
        fif.fetch_retry     = 1'b0;
        ready_pct = 100; resp_pct = 100; retry_pct = 0; lat_max = 0; mem_hold = 1'b0;

        // Reset, then a streaming single-cycle memory.
        repeat (3) tick(1'b1, 1'b0, '0);
        repeat (30) tick(1'b0, 1'b0, '0);

        // Decode stall: credits run out, head held, stream resumes intact.
        retry_pct = 100;
        repeat (10) tick(1'b0, 1'b0, '0);
        retry_pct = 0;
        repeat (15) tick(1'b0, 1'b0, '0);

        // Build up three outstanding requests, then redirect to 0x1002.
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && pending.size() < 3; i++) tick(1'b0, 1'b0, '0);
        chk("inflight_fill", 64'(pending.size()), 64'd3);
        tick(1'b0, 1'b1, 64'h1002);
        mem_hold = 1'b0;
        repeat (20) tick(1'b0, 1'b0, '0);

        // Redirect during a steady stream (response and consumable head
        // coincide) to the top of the address space, which then wraps.
        tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (20) tick(1'b0, 1'b0, '0);

        // Reset with a non-empty queue.
        retry_pct = 100;
        repeat (6) tick(1'b0, 1'b0, '0);
        repeat (2) tick(1'b1, 1'b0, '0);
        retry_pct = 0;
        repeat (20) tick(1'b0, 1'b0, '0);

        // Randomized traffic: stalls, latency, back-to-back redirects, resets.
        ready_pct = 75; resp_pct = 70; retry_pct = 30; lat_max = 3;
        repeat (3000) begin
            rnd = int'($urandom_range(0, 999));
            if (rnd < 4)       tick(1'b1, 1'b0, '0);
            else if (rnd < 50) tick(1'b0, 1'b1, {$urandom, $urandom});
            else               tick(1'b0, 1'b0, '0);
        end

        ready_pct = 100; resp_pct = 100; retry_pct = 0; lat_max = 0;
        repeat (20) tick(1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
